// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller: op codes, FSM
// state encodings and the stall request levels.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } mdu_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  function automatic logic is_mul_op(mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage side of the multiply/divide controller: the instruction presented
// by EX and the stall request returned to the stall controller.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic        op_valid;
  mdu_op_e     op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        annul;
  logic        stallreq;

  modport master (output op_valid, op, src1, src2, annul, input stallreq);
  modport slave  (input op_valid, op, src1, src2, annul, output stallreq);

endinterface

// File: rtl/mdu_fsm.sv
// Sequencing for the multiply/divide controller: state register, the shared
// latency/timeout counter and the next-state / stall decode.
module mdu_fsm
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  mdu_op_e    op,
  input  logic       src2_zero,
  input  logic       annul,
  input  logic       div_ready,
  output mdu_state_e state,
  output logic       mul_go,
  output logic       div_go,
  output logic       mul_wr,
  output logic       div_wr,
  output logic       div_abort,
  output logic       stallreq
);

  localparam int CNT_MAX = (DIV_TIMEOUT > MUL_LAT) ? DIV_TIMEOUT : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_go    = 1'b0;
    div_go    = 1'b0;
    mul_wr    = 1'b0;
    div_wr    = 1'b0;
    div_abort = 1'b0;
    stallreq  = NO_STOP;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !annul) begin
          if (is_mul_op(op)) begin
            mul_go   = 1'b1;
            stallreq = STOP;
            cnt_d    = MUL_LOAD;
            state_d  = ST_MUL_WAIT;
          end else if (is_div_op(op) && !src2_zero) begin
            div_go   = 1'b1;
            stallreq = STOP;
            cnt_d    = '0;
            state_d  = ST_DIV_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        stallreq = STOP;
        if (annul) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          mul_wr  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_WAIT: begin
        stallreq = STOP;
        // Annul beats a same-cycle result; a real result beats the timeout.
        if (annul || (!div_ready && cnt_q == DIV_LAST)) begin
          div_abort = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (div_ready) begin
          div_wr  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: issues MULT/DIV work to external units, stalls
// EX while they run, and owns the architectural HI/LO registers.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  mdu_ctrl_if.slave        ex,
  output logic             mul_signed,
  output logic [31:0]      mul_ina,
  output logic [31:0]      mul_inb,
  input  logic [63:0]      mul_result,
  output logic             div_start,
  output logic             div_signed,
  output logic             div_annul,
  output logic [31:0]      div_opdata1,
  output logic [31:0]      div_opdata2,
  input  logic [63:0]      div_result,
  input  logic             div_ready,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic             busy
);

  mdu_state_e state;
  logic       mul_go, div_go, mul_wr, div_wr, div_abort;
  logic       src2_zero;
  logic       mt_ok;

  assign src2_zero = (ex.src2 == '0);

  mdu_fsm #(
    .MUL_LAT     (MUL_LAT),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (ex.op_valid),
    .op        (ex.op),
    .src2_zero (src2_zero),
    .annul     (ex.annul),
    .div_ready (div_ready),
    .state     (state),
    .mul_go    (mul_go),
    .div_go    (div_go),
    .mul_wr    (mul_wr),
    .div_wr    (div_wr),
    .div_abort (div_abort),
    .stallreq  (ex.stallreq)
  );

  // Operands are captured at issue and held for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_signed  <= 1'b0;
      mul_ina     <= '0;
      mul_inb     <= '0;
      div_signed  <= 1'b0;
      div_opdata1 <= '0;
      div_opdata2 <= '0;
      div_start   <= 1'b0;
      div_annul   <= 1'b0;
    end else begin
      if (mul_go) begin
        mul_signed <= is_signed_op(ex.op);
        mul_ina    <= ex.src1;
        mul_inb    <= ex.src2;
      end
      if (div_go) begin
        div_signed  <= is_signed_op(ex.op);
        div_opdata1 <= ex.src1;
        div_opdata2 <= ex.src2;
        div_start   <= 1'b1;
      end else if (div_wr || div_abort) begin
        div_start <= 1'b0;
      end
      div_annul <= div_abort;
    end
  end

  assign mt_ok = (state == ST_IDLE) && ex.op_valid && !ex.annul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_wr) begin
      hi <= mul_result[63:32];
      lo <= mul_result[31:0];
    end else if (div_wr) begin
      hi <= div_result[63:32];
      lo <= div_result[31:0];
    end else if (mt_ok && ex.op == OP_MTHI) begin
      hi <= ex.src1;
    end else if (mt_ok && ex.op == OP_MTLO) begin
      lo <= ex.src1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with behavioural multiplier/divider models
// and a HI/LO scoreboard.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_LAT     = 2;
  localparam int DIV_TIMEOUT = 40;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  logic        clk = 1'b0;
  logic        rst;
  mdu_ctrl_if  ex ();
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic [31:0] hi, lo;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  hilo_t       sb_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int unsigned ready_at = 33;
  int unsigned div_cnt  = 0;
  logic [63:0] mul_q    = '0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex          (ex),
    .mul_signed  (mul_signed),
    .mul_ina     (mul_ina),
    .mul_inb     (mul_inb),
    .mul_result  (mul_result),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_annul   (div_annul),
    .div_opdata1 (div_opdata1),
    .div_opdata2 (div_opdata2),
    .div_result  (div_result),
    .div_ready   (div_ready),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(logic s, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] div_ref(logic s, logic [31:0] a, logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    if (b == '0) return '0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier with MUL_LAT=2: product valid the cycle after operands appear.
  always @(posedge clk) mul_q <= mul_ref(mul_signed, mul_ina, mul_inb);
  assign mul_result = mul_q;

  // Divider answers ready_at cycles after div_start rises.
  always @(posedge clk) div_cnt <= div_start ? div_cnt + 1 : 0;
  assign div_ready  = div_start && (div_cnt == ready_at);
  assign div_result = div_ref(div_signed, div_opdata1, div_opdata2);

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic v, mdu_op_e o, logic [31:0] a, logic [31:0] b, logic an);
    ex.op_valid = v;
    ex.op       = o;
    ex.src1     = a;
    ex.src2     = b;
    ex.annul    = an;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, OP_RSVD6, '0, '0, 1'b0);
  endtask

  task automatic sb_push(logic [31:0] h, logic [31:0] l);
    hilo_t e;
    e.hi = h;
    e.lo = l;
    sb_q.push_back(e);
    exp_hi = h;
    exp_lo = l;
  endtask

  task automatic sb_check(string tag);
    hilo_t e;
    check({tag, ":sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ":hi"}, hi, e.hi);
      check({tag, ":lo"}, lo, e.lo);
    end
  endtask

  // Issue one MULT/DIV class op, hold it in EX until DONE, then score HI/LO.
  task automatic run_op(string tag, mdu_op_e o, logic [31:0] a, logic [31:0] b,
                        int exp_stalls, logic [31:0] e_hi, logic [31:0] e_lo);
    int stalls;
    bit reached_done;
    stalls       = 0;
    reached_done = 1'b0;
    sb_push(e_hi, e_lo);
    drive(1'b1, o, a, b, 1'b0);
    check({tag, ":issue_stall"}, ex.stallreq, STOP);
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!busy) break;
      if (ex.stallreq == STOP) stalls++;
      else begin
        reached_done = 1'b1;
        break;
      end
    end
    if (!reached_done) drive_idle();
    check({tag, ":done"}, reached_done, 1'b1);
    check({tag, ":stall_cycles"}, stalls, exp_stalls);
    tick();
    drive_idle();
    check({tag, ":idle"}, busy, 1'b0);
    sb_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    mdu_op_e     o;
    int          stalls;

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;
    check("rst:hi", hi, 0);
    check("rst:lo", lo, 0);
    check("rst:busy", busy, 0);
    check("rst:stallreq", ex.stallreq, NO_STOP);
    check("rst:div_start", div_start, 0);
    check("rst:div_annul", div_annul, 0);
    check("rst:mul_ops", {mul_ina, mul_inb}, 0);
    check("rst:div_ops", {div_opdata1, div_opdata2}, 0);
    @(negedge clk) rst = 1'b0;

    // MTHI then MTLO back to back, never stalling
    drive(1'b1, OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    check("mthi:stall", ex.stallreq, NO_STOP);
    tick();
    check("mthi:hi", hi, 32'h1234_5678);
    check("mthi:lo", lo, 32'h0);
    drive(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
    check("mtlo:stall", ex.stallreq, NO_STOP);
    tick();
    drive_idle();
    check("mtlo:lo", lo, 32'h9ABC_DEF0);
    check("mtlo:hi", hi, 32'h1234_5678);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h9ABC_DEF0;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      o = (i % 2 == 1) ? OP_MULTU : OP_MULT;
      p = mul_ref(o == OP_MULT, a, b);
      run_op($sformatf("mul_rand%0d", i), o, a, b, MUL_LAT, p[63:32], p[31:0]);
    end

    ready_at = 33;
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
    run_op("div_neg100_7", OP_DIV, -32'sd100, 32'd7, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    for (int i = 0; i < 2; i++) begin
      a        = $urandom;
      b        = $urandom_range(1, 5000);
      o        = (i == 0) ? OP_DIV : OP_DIVU;
      ready_at = $urandom_range(1, 20);
      p        = div_ref(o == OP_DIV, a, b);
      run_op($sformatf("div_rand%0d", i), o, a, b, int'(ready_at) + 1, p[63:32], p[31:0]);
    end

    // Divide by zero: nothing starts, nothing stalls
    drive(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
    check("div0:stall", ex.stallreq, NO_STOP);
    tick();
    check("div0:div_start", div_start, 0);
    check("div0:busy", busy, 0);
    check("div0:stall2", ex.stallreq, NO_STOP);
    drive_idle();
    check("div0:hilo", {hi, lo}, {exp_hi, exp_lo});

    // Annul in IDLE suppresses MTHI and a multiply start
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
    tick();
    check("annul_idle:hi", hi, exp_hi);
    drive(1'b1, OP_MULT, 32'd4, 32'd5, 1'b1);
    check("annul_idle:stall", ex.stallreq, NO_STOP);
    tick();
    drive_idle();
    check("annul_idle:busy", busy, 0);

    // Annul in MUL_WAIT
    sb_push(exp_hi, exp_lo);
    drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    tick();
    check("mul_annul:mul_signed", mul_signed, 0);
    check("mul_annul:operands", {mul_ina, mul_inb}, {32'hFFFF_FFFF, 32'd2});
    drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    tick();
    drive_idle();
    check("mul_annul:busy", busy, 0);
    check("mul_annul:div_annul", div_annul, 0);
    tick();
    sb_check("mul_annul");

    // Annul at DIV_WAIT cycle 5
    ready_at = 33;
    sb_push(exp_hi, exp_lo);
    drive(1'b1, OP_DIV, -32'sd50, 32'd3, 1'b0);
    tick();
    check("div_annul:div_start", div_start, 1);
    check("div_annul:div_signed", div_signed, 1);
    repeat (5) tick();
    drive(1'b1, OP_DIV, -32'sd50, 32'd3, 1'b1);
    tick();
    drive_idle();
    check("div_annul:busy", busy, 0);
    check("div_annul:pulse", div_annul, 1);
    check("div_annul:div_start_low", div_start, 0);
    tick();
    check("div_annul:pulse_end", div_annul, 0);
    sb_check("div_annul");

    // Annul and div_ready in the same cycle
    ready_at = 3;
    sb_push(exp_hi, exp_lo);
    drive(1'b1, OP_DIVU, 32'd77, 32'd5, 1'b0);
    tick();
    repeat (3) tick();
    drive(1'b1, OP_DIVU, 32'd77, 32'd5, 1'b1);
    check("annul_ready:ready_seen", div_ready, 1);
    tick();
    drive_idle();
    check("annul_ready:busy", busy, 0);
    check("annul_ready:pulse", div_annul, 1);
    sb_check("annul_ready");

    // Divider never answers: forced abort after DIV_TIMEOUT cycles
    ready_at = 1000;
    sb_push(exp_hi, exp_lo);
    stalls = 0;
    drive(1'b1, OP_DIVU, 32'd9, 32'd3, 1'b0);
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!busy) break;
      if (ex.stallreq == STOP) stalls++;
    end
    drive_idle();
    check("timeout:stall_cycles", stalls, DIV_TIMEOUT);
    check("timeout:pulse", div_annul, 1);
    sb_check("timeout");
    tick();
    check("timeout:pulse_end", div_annul, 0);

    // Reset in the middle of a divide
    drive(1'b1, OP_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
    tick();
    drive(1'b1, OP_MTLO, 32'h5A5A_5A5A, 32'h0, 1'b0);
    tick();
    check("pre_rst:hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
    ready_at = 33;
    drive(1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
    tick();
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    check("mid_rst:hi", hi, 0);
    check("mid_rst:lo", lo, 0);
    check("mid_rst:busy", busy, 0);
    check("mid_rst:div_start", div_start, 0);
    drive_idle();
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk) rst = 1'b0;
    run_op("post_rst", OP_MULTU, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2, cycles from operands presented to mul_result valid (range 1-7).
REQ-002 Parameter DIV_TIMEOUT, default 40, maximum DIV_WAIT cycles before forced abort.
REQ-003 clk  in  1  the only clock; all state on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 op_valid  in  1  EX holds a multiply/divide-class instruction this cycle.
REQ-006 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op.
REQ-007 src1, src2  in  32 each  rs/rt operand values, already forwarded.
REQ-008 annul  in  1  flush of the EX instruction.
REQ-009 stallreq  out  1  EX stall request to the stall controller.
REQ-010 mul_signed, mul_ina, mul_inb  out  1/32/32  multiplier controls.
REQ-011 mul_result  in  64  multiplier product.
REQ-012 div_start, div_signed, div_annul, div_opdata1, div_opdata2  out  1/1/1/32/32  divider controls.
REQ-013 div_result  in  64  {remainder, quotient}; div_ready  in  1  result valid.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.
REQ-015 busy  out  1  state is not IDLE.

Function
REQ-016 States IDLE, MUL_WAIT, DIV_WAIT, DONE, encoded in 2 bits.
REQ-017 IDLE with op_valid, op MULT/MULTU, annul=0: drive mul operands, stallreq=1, load counter with MUL_LAT-1, go MUL_WAIT.
REQ-018 MUL_WAIT: operands and mul_signed held stable; stallreq=1; decrement counter; at counter 0 write hi=mul_result[63:32], lo=mul_result[31:0], go DONE.
REQ-019 IDLE with op DIV/DIVU, src2!=0: div_start=1, stallreq=1, go DIV_WAIT.
REQ-020 DIV_WAIT: div_start held 1, operands latched internally and held stable; stallreq=1 until div_ready.
REQ-021 div_ready in DIV_WAIT: hi=div_result[63:32], lo=div_result[31:0], div_start=0 that cycle, go DONE.
REQ-022 DONE: stallreq=0 for exactly one cycle, op_valid ignored (same instruction retires), go IDLE.
REQ-023 DIV/DIVU with src2==0: no divider start, no stall, HI/LO unchanged, stay IDLE.
REQ-024 MTHI/MTLO in IDLE: write hi (or lo) with src1 at next edge, no stall; other register unchanged.
REQ-025 annul in MUL_WAIT or DIV_WAIT: no HI/LO write, div_start=0, div_annul=1 for one cycle (DIV_WAIT only), go IDLE next edge.
REQ-026 annul and div_ready in same cycle: annul wins, result discarded.
REQ-027 annul in IDLE suppresses any start or MTHI/MTLO write that cycle.
REQ-028 DIV_WAIT count reaching DIV_TIMEOUT: treat as annul (REQ-025), HI/LO unchanged.
REQ-029 stallreq is combinational from state and inputs; all other outputs registered or state-decoded.
REQ-030 Signedness: op MULT/DIV set mul_signed/div_signed=1, MULTU/DIVU set 0.

Reset
REQ-031 rst forces IDLE, hi=0, lo=0, counters 0, stallreq=0, div_start=0, div_annul=0, busy=0, operand outputs 0.
REQ-032 rst mid-operation aborts immediately without HI/LO write; first post-reset edge accepts a new op.

Structure
REQ-033 Op encodings, state encodings and Stop/NoStop constants reside in the shared defines package.
REQ-034 One sub-module, mdu_fsm (state register, counters, next-state logic); HI/LO file stays in mdu_ctrl.

Verification
REQ-035 MULT src1=0xFFFFFFFE, src2=3, MUL_LAT=2 -> stallreq high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, one DONE cycle.
REQ-036 DIVU src1=100, src2=7, div_ready after 33 cycles -> stallreq high until ready, hi=2, lo=14.
REQ-037 DIV src2=0 -> stallreq never asserts, div_start stays 0, hi/lo unchanged.
REQ-038 DIV started, annul at cycle 5 -> div_annul pulses once, IDLE next cycle, hi/lo unchanged.
REQ-039 annul and div_ready same cycle -> no HI/LO write, IDLE next cycle.
REQ-040 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi/lo updated one cycle each, stallreq=0 throughout; rst asserted mid-DIV -> IDLE, hi=lo=0 immediately.
